// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for a single-ported unified I/D memory shared by the IF and MEM stages.
// Data has priority. A fetch that has waited through STARVE_MAX data grants is forced through next.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1) < 1 ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic { ST_IDLE, ST_WAIT } state_e;
  typedef enum logic { OWN_IF, OWN_DM } owner_e;

  state_e            state_q,     state_d;
  owner_e            owner_q,     owner_d;
  logic              op_we_q,     op_we_d;
  logic [LAT_W-1:0]  lat_cnt_q,   lat_cnt_d;
  logic [STV_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_valid_q,  if_valid_d;
  logic              dm_valid_q,  dm_valid_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;

  logic if_elig;
  logic dm_elig;
  logic pick_if;

  // A requester is blind in its own completion cycle, so a held req is not re-served twice.
  assign if_elig = if_req & ~if_valid_q;
  assign dm_elig = dm_req & ~dm_valid_q;
  assign pick_if = if_elig & (~dm_elig | (starve_cnt_q == STV_W'(STARVE_MAX)));

  always_comb begin
    // NOTE: every _d gets a default first; a missed branch would otherwise infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    op_we_d      = op_we_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_valid_d   = 1'b0;
    dm_valid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (if_elig || dm_elig) begin
          mem_en_d  = 1'b1;
          lat_cnt_d = LAT_W'(MEM_LAT);
          state_d   = ST_WAIT;
          if (pick_if) begin
            owner_d      = OWN_IF;
            op_we_d      = 1'b0;
            mem_addr_d   = if_addr;
            starve_cnt_d = '0;
          end else begin
            owner_d     = OWN_DM;
            op_we_d     = dm_we;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            if (if_elig) starve_cnt_d = starve_cnt_q + STV_W'(1);
          end
        end
      end

      ST_WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            if (!op_we_q) dm_rdata_d = mem_rdata;
            dm_valid_d = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so flop order never matters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      op_we_q      <= 1'b0;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_valid_q   <= 1'b0;
      dm_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      op_we_q      <= op_we_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_valid_q   <= if_valid_d;
      dm_valid_q   <= dm_valid_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  assign if_stall = if_req & ~if_valid_q;
  assign dm_stall = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. A small memory model returns data MEM_LAT cycles after a read strobe.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              dm_stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = 32'hBAD0_BAD0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h0050_0093;
      32'h0000_0100: return 32'hDEAD_BEEF;
      default:       return {a[15:0], 16'hC0DE};
    endcase
  endfunction

  // Read data is only correct in the exact cycle it is due; garbage otherwise.
  logic              pipe_v    [MEM_LAT] = '{default: 1'b0};
  logic [ADDR_W-1:0] pipe_addr [MEM_LAT] = '{default: '0};
  always @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) begin
      pipe_v[i]    = pipe_v[i-1];
      pipe_addr[i] = pipe_addr[i-1];
    end
    pipe_v[0]    = mem_en & ~mem_we;
    pipe_addr[0] = mem_addr;
    #1 mem_rdata = pipe_v[MEM_LAT-1] ? data_of(pipe_addr[MEM_LAT-1]) : 32'hBAD0_BAD0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, " mem_en"},    32'(mem_en),    32'h0);
    check({tag, " mem_we"},    32'(mem_we),    32'h0);
    check({tag, " mem_addr"},  mem_addr,       32'h0);
    check({tag, " mem_wdata"}, mem_wdata,      32'h0);
    check({tag, " if_valid"},  32'(if_valid),  32'h0);
    check({tag, " dm_valid"},  32'(dm_valid),  32'h0);
    check({tag, " if_rdata"},  if_rdata,       32'h0);
    check({tag, " dm_rdata"},  dm_rdata,       32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

    // Reset held with random traffic.
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      if_req = 1'($urandom_range(0, 1)); dm_req = 1'($urandom_range(0, 1));
      dm_we = 1'($urandom_range(0, 1)); if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
      sample();
      check_regs_zero("reset");
    end
    next_cycle();
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      check("idle mem_en", 32'(mem_en), 32'h0);
      check("idle if_stall", 32'(if_stall), 32'h0);
      next_cycle();
    end

    // Single fetch.
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) next_cycle();
      if (c == 0) begin if_req = 1'b1; if_addr = 32'h10; end
      if (c == 5) if_req = 1'b0;
      sample();
      case (c)
        0: begin check("fetch c0 stall", 32'(if_stall), 32'h1); check("fetch c0 mem_en", 32'(mem_en), 32'h0); end
        1: begin
          check("fetch c1 mem_en", 32'(mem_en), 32'h1);
          check("fetch c1 mem_addr", mem_addr, 32'h10);
          check("fetch c1 mem_we", 32'(mem_we), 32'h0);
          check("fetch c1 stall", 32'(if_stall), 32'h1);
        end
        2, 3: begin
          check("fetch wait stall", 32'(if_stall), 32'h1);
          check("fetch wait valid", 32'(if_valid), 32'h0);
          check("fetch wait mem_en", 32'(mem_en), 32'h0);
        end
        4: begin
          check("fetch c4 valid", 32'(if_valid), 32'h1);
          check("fetch c4 rdata", if_rdata, 32'h0050_0093);
          check("fetch c4 stall", 32'(if_stall), 32'h0);
        end
        default: begin
          check("fetch c5 valid pulse", 32'(if_valid), 32'h0);
          check("fetch c5 mem_en", 32'(mem_en), 32'h0);
          check("fetch rdata hold", if_rdata, 32'h0050_0093);
        end
      endcase
    end

    // Collision: data load wins, fetch follows in the data valid cycle.
    for (int c = 0; c <= 9; c++) begin
      next_cycle();
      if (c == 0) begin if_req = 1'b1; if_addr = 32'h14; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; end
      if (c == 5) dm_req = 1'b0;
      if (c == 9) if_req = 1'b0;
      sample();
      case (c)
        0: begin check("coll c0 if_stall", 32'(if_stall), 32'h1); check("coll c0 dm_stall", 32'(dm_stall), 32'h1); end
        1: begin check("coll c1 mem_en", 32'(mem_en), 32'h1); check("coll c1 mem_addr", mem_addr, 32'h100); end
        4: begin
          check("coll c4 dm_valid", 32'(dm_valid), 32'h1);
          check("coll c4 dm_rdata", dm_rdata, 32'hDEAD_BEEF);
          check("coll c4 dm_stall", 32'(dm_stall), 32'h0);
          check("coll c4 if_stall", 32'(if_stall), 32'h1);
        end
        5: begin check("coll c5 mem_en", 32'(mem_en), 32'h1); check("coll c5 mem_addr", mem_addr, 32'h14); end
        7: check("coll c7 if_stall", 32'(if_stall), 32'h1);
        8: begin
          check("coll c8 if_valid", 32'(if_valid), 32'h1);
          check("coll c8 if_rdata", if_rdata, 32'h0014_C0DE);
          check("coll c8 if_stall", 32'(if_stall), 32'h0);
        end
        default: ;
      endcase
    end

    // Store: data after grant must not leak into the access; dm_rdata keeps the last load.
    for (int c = 0; c <= 5; c++) begin
      next_cycle();
      if (c == 0) begin dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h104; dm_wdata = 32'h1234_5678; end
      if (c == 1) dm_wdata = 32'hFFFF_FFFF;
      if (c == 5) begin dm_req = 1'b0; dm_we = 1'b0; end
      sample();
      case (c)
        1: begin
          check("store c1 mem_en", 32'(mem_en), 32'h1);
          check("store c1 mem_we", 32'(mem_we), 32'h1);
          check("store c1 mem_addr", mem_addr, 32'h104);
          check("store c1 mem_wdata", mem_wdata, 32'h1234_5678);
        end
        2: check("store c2 mem_we", 32'(mem_we), 32'h0);
        3: begin check("store c3 dm_valid", 32'(dm_valid), 32'h0); check("store c3 dm_stall", 32'(dm_stall), 32'h1); end
        4: begin check("store c4 dm_valid", 32'(dm_valid), 32'h1); check("store c4 dm_rdata", dm_rdata, 32'hDEAD_BEEF); end
        default: ;
      endcase
    end

    // Starvation: fetch drops only in data-valid cycles, so each later arbitration is a collision.
    for (int c = 0; c <= 28; c++) begin
      next_cycle();
      if (c == 0) begin if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; end
      if (c < 20 && c % 5 == 4) if_req = 1'b0;
      if (c > 0 && c <= 20 && c % 5 == 0) if_req = 1'b1;
      if (c == 25) begin if_req = 1'b0; dm_req = 1'b0; end
      sample();
      if (c < 20 && c % 5 == 1) begin
        check("starve dm grant mem_en", 32'(mem_en), 32'h1);
        check("starve dm grant addr", mem_addr, 32'h200);
      end
      if (c < 20 && c % 5 == 4) check("starve dm_valid", 32'(dm_valid), 32'h1);
      if (c == 21) begin
        check("starve forced fetch mem_en", 32'(mem_en), 32'h1);
        check("starve forced fetch addr", mem_addr, 32'h20);
      end
      if (c == 24) begin
        check("starve if_valid", 32'(if_valid), 32'h1);
        check("starve if_rdata", if_rdata, 32'h0020_C0DE);
      end
      if (c == 25) check("starve dm after fetch addr", mem_addr, 32'h200);
      if (c == 28) begin
        check("dropped req dm_valid", 32'(dm_valid), 32'h1);
        check("dropped req dm_rdata", dm_rdata, 32'h0200_C0DE);
      end
    end

    // Starve counter was cleared by the forced fetch: data wins the next collision.
    for (int c = 0; c <= 9; c++) begin
      next_cycle();
      if (c == 0) begin if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_addr = 32'h300; end
      if (c == 5) dm_req = 1'b0;
      if (c == 9) if_req = 1'b0;
      sample();
      if (c == 1) check("post-starve dm wins", mem_addr, 32'h300);
      if (c == 5) check("post-starve fetch next", mem_addr, 32'h40);
      if (c == 8) check("post-starve if_rdata", if_rdata, 32'h0040_C0DE);
    end

    // Reset mid-transaction.
    for (int c = 0; c <= 14; c++) begin
      next_cycle();
      if (c == 0) begin if_req = 1'b1; if_addr = 32'h30; end
      if (c == 2) begin
        rst = 1'b1; if_req = 1'b0;
        #1;
        check_regs_zero("mid-op reset");
      end
      if (c == 3) rst = 1'b0;
      if (c == 9) if_req = 1'b1;
      if (c == 14) if_req = 1'b0;
      sample();
      if (c == 1) check("mid-op c1 mem_addr", mem_addr, 32'h30);
      if (c >= 3 && c <= 8) begin
        check("after reset no if_valid", 32'(if_valid), 32'h0);
        check("after reset no mem_en", 32'(mem_en), 32'h0);
      end
      if (c == 10) check("rerequest mem_en", 32'(mem_en), 32'h1);
      if (c == 12) check("rerequest not early", 32'(if_valid), 32'h0);
      if (c == 13) begin
        check("rerequest if_valid", 32'(if_valid), 32'h1);
        check("rerequest if_rdata", if_rdata, 32'h0030_C0DE);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
